// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared register-file defines used by the writeback controller and the
// register file. Also holds the writeback source encoding used by the arbiter.
package regfile_wb_ctrl_pkg;

  localparam int RF_WORD_WIDTH     = 16;
  localparam int RF_NUM_REGS       = 16;
  localparam int RF_REG_ADDR_WIDTH = 4;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_e;

endpackage

// File: rtl/regfile_wb_ctrl_fifo2.sv
// wb_fifo2: two-entry FIFO with registered head. Push and pop on the same
// edge are allowed even when full, so the count stays put and nothing is lost.
module wb_fifo2
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == 2'd0);
  assign o_full  = (r_count == 2'd2);
  assign o_head  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  // Pointer and occupancy tracking; reset discards whatever was stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage, no reset needed since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: merges ALU and load results into the single register-file
// write port through per-source 2-entry FIFOs and a round-robin arbiter, and
// keeps a pending-write scoreboard for issue-time WAW stalls.
// Optional feature macro: WB_BYPASS_EN adds two combinational bypass ports
// that forward the value being written this cycle.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int WORD_WIDTH     = RF_WORD_WIDTH,
  parameter int NUM_REGS       = RF_NUM_REGS,
  parameter int REG_ADDR_WIDTH = RF_REG_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_alu_valid,
  output logic                      o_alu_ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_alu_rd,
  input  logic [WORD_WIDTH-1:0]     i_alu_data,
  input  logic                      i_mem_valid,
  output logic                      o_mem_ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_mem_rd,
  input  logic [WORD_WIDTH-1:0]     i_mem_data,
  input  logic                      i_issue_valid,
  output logic                      o_issue_ready,
  input  logic [REG_ADDR_WIDTH-1:0] i_issue_rd,
  output logic [NUM_REGS-1:0]       o_busy,
  output logic                      o_rf_write_en,
  output logic [REG_ADDR_WIDTH-1:0] o_rf_write_addr,
  output logic [WORD_WIDTH-1:0]     o_rf_write_data
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_ADDR_WIDTH-1:0] i_byp_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] i_byp_addr2,
  output logic                      o_byp_hit1,
  output logic                      o_byp_hit2,
  output logic [WORD_WIDTH-1:0]     o_byp_data1,
  output logic [WORD_WIDTH-1:0]     o_byp_data2
`endif
);

  localparam int EW = REG_ADDR_WIDTH + WORD_WIDTH;

  logic [EW-1:0]             w_alu_head;
  logic [EW-1:0]             w_mem_head;
  logic [EW-1:0]             w_grant_head;
  logic                      w_alu_full, w_alu_empty;
  logic                      w_mem_full, w_mem_empty;
  logic                      w_alu_push, w_mem_push;
  logic                      w_alu_pop, w_mem_pop;
  logic                      w_grant;
  logic [REG_ADDR_WIDTH-1:0] w_grant_rd;
  logic                      w_issue_fire;
  logic [NUM_REGS-1:0]       w_busy_nxt;

  logic                      r_wr_en;
  logic [REG_ADDR_WIDTH-1:0] r_wr_addr;
  logic [WORD_WIDTH-1:0]     r_wr_data;
  logic [NUM_REGS-1:0]       r_busy;
  wb_src_e                   r_last_src;

  assign o_alu_ready = !w_alu_full;
  assign o_mem_ready = !w_mem_full;
  assign w_alu_push  = i_alu_valid && o_alu_ready;
  assign w_mem_push  = i_mem_valid && o_mem_ready;

  wb_fifo2 #(.WIDTH(EW)) u_alu_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_alu_push),
    .i_data  ({i_alu_rd, i_alu_data}),
    .i_pop   (w_alu_pop),
    .o_head  (w_alu_head),
    .o_full  (w_alu_full),
    .o_empty (w_alu_empty)
  );

  wb_fifo2 #(.WIDTH(EW)) u_mem_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_mem_push),
    .i_data  ({i_mem_rd, i_mem_data}),
    .i_pop   (w_mem_pop),
    .o_head  (w_mem_head),
    .o_full  (w_mem_full),
    .o_empty (w_mem_empty)
  );

  // Round-robin grant: on contention the source not granted last wins.
  always_comb begin
    w_alu_pop    = 1'b0;
    w_mem_pop    = 1'b0;
    w_grant_head = '0;
    if (!w_alu_empty && (w_mem_empty || r_last_src == SRC_MEM)) begin
      w_alu_pop    = 1'b1;
      w_grant_head = w_alu_head;
    end else if (!w_mem_empty) begin
      w_mem_pop    = 1'b1;
      w_grant_head = w_mem_head;
    end
  end

  assign w_grant    = w_alu_pop || w_mem_pop;
  assign w_grant_rd = w_grant_head[EW-1:WORD_WIDTH];

  // Registered write port; r0 results are popped but never written.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_last_src <= SRC_MEM;
    end else begin
      r_wr_en <= w_grant && (w_grant_rd != '0);
      if (w_grant && (w_grant_rd != '0)) begin
        r_wr_addr <= w_grant_rd;
        r_wr_data <= w_grant_head[WORD_WIDTH-1:0];
      end
      if (w_grant) r_last_src <= w_alu_pop ? SRC_ALU : SRC_MEM;
    end
  end

  assign o_issue_ready = !r_busy[i_issue_rd];
  assign w_issue_fire  = i_issue_valid && o_issue_ready && (i_issue_rd != '0);

  // Scoreboard update: retire clears first so a same-edge claim wins.
  always_comb begin
    w_busy_nxt = r_busy;
    if (r_wr_en)      w_busy_nxt[r_wr_addr]  = 1'b0;
    if (w_issue_fire) w_busy_nxt[i_issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  assign o_busy          = r_busy;
  assign o_rf_write_en   = r_wr_en;
  assign o_rf_write_addr = r_wr_addr;
  assign o_rf_write_data = r_wr_data;

`ifdef WB_BYPASS_EN
  assign o_byp_hit1  = r_wr_en && (i_byp_addr1 == r_wr_addr) && (i_byp_addr1 != '0);
  assign o_byp_hit2  = r_wr_en && (i_byp_addr2 == r_wr_addr) && (i_byp_addr2 != '0);
  assign o_byp_data1 = r_wr_data;
  assign o_byp_data2 = r_wr_data;
`endif

endmodule

// File: doc/regfile_wb_ctrl.md
REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

Interface
REQ-001 SHALL have parameters: WORD_WIDTH, 16, data width; NUM_REGS, 16, register count; REG_ADDR_WIDTH, 4, register address width.
REQ-002 SHALL have ports: clk input 1 clock; rst input 1 reset, asynchronous, active-high.
REQ-003 SHALL have ports: alu_valid input 1, alu_ready output 1, alu_rd input REG_ADDR_WIDTH, alu_data input WORD_WIDTH; ALU result channel.
REQ-004 SHALL have ports: mem_valid input 1, mem_ready output 1, mem_rd input REG_ADDR_WIDTH, mem_data input WORD_WIDTH; load result channel.
REQ-005 SHALL have ports: issue_valid input 1, issue_ready output 1, issue_rd input REG_ADDR_WIDTH; destination claim at instruction issue.
REQ-006 SHALL have ports: busy output NUM_REGS, scoreboard, bit i set means register i has a pending write.
REQ-007 SHALL have ports: rf_write_en output 1, rf_write_addr output REG_ADDR_WIDTH, rf_write_data output WORD_WIDTH; drive the register file write port.

Function
REQ-008 SHALL buffer each result channel in its own 2-entry FIFO; a beat transfers on a clock edge with valid&&ready.
REQ-009 SHALL drive alu_ready/mem_ready from FIFO occupancy only (occupancy<2), never from valid.
REQ-010 SHALL select at most one FIFO head per cycle, round-robin: if both non-empty, grant the source not granted last; if one non-empty, grant it.
REQ-011 SHALL register the grant: head popped on edge E1 appears on rf_write_* during the cycle after E1; a beat accepted on edge E0 into an empty FIFO with no contention pops on E1 (minimum latency 1 cycle from accept to rf_write_en high).
REQ-012 SHALL pop entries with rd=0 normally but hold rf_write_en low for them.
REQ-013 SHALL hold rf_write_en low in cycles with no grant; rf_write_addr/data hold their last values.
REQ-014 SHALL set busy[issue_rd] on an edge with issue_valid&&issue_ready and issue_rd!=0; busy[0] SHALL stay 0.
REQ-015 SHALL deassert issue_ready combinationally when busy[issue_rd]=1 (WAW stall), else assert it.
REQ-016 SHALL clear busy[rf_write_addr] on the edge that ends a cycle with rf_write_en=1.
REQ-017 SHALL give set priority when issue sets and writeback clears the same register on one edge (busy ends 1).
REQ-018 SHALL allow a FIFO push and pop on the same edge when full (count stays 2, no data loss).

Reset
REQ-019 SHALL on rst: empty both FIFOs, busy=0, rf_write_en=0, rf_write_addr=0, rf_write_data=0, round-robin pointer to favour ALU first.
REQ-020 SHALL discard in-flight FIFO contents on rst asserted mid-operation; alu_ready/mem_ready=1 while rst is high.

Configuration
REQ-021 SHALL, with WB_BYPASS_EN defined, add inputs byp_addr1/byp_addr2 (REG_ADDR_WIDTH) and outputs byp_hit1/byp_hit2 (1), byp_data1/byp_data2 (WORD_WIDTH): hitN=rf_write_en && byp_addrN==rf_write_addr && byp_addrN!=0, dataN=rf_write_data, combinational.
REQ-022 SHALL, without WB_BYPASS_EN, omit those ports entirely; all other behaviour is identical.

Structure
REQ-023 SHALL take WORD_WIDTH, NUM_REGS and REG_ADDR_WIDTH defaults from the shared defines header used by the register file.
REQ-024 SHALL implement each FIFO as one instance of sub-module wb_fifo2 (parameterised by entry width, push/pop/full/empty/head).

Verification
REQ-025 SHALL test: alu beat rd=3 data=0x1234 after issue rd=3 -> rf_write_en=1, addr=3, data=0x1234 one cycle after accept; busy[3] 1->0.
REQ-026 SHALL test: alu rd=1 and mem rd=2 accepted on the same edge, pointer reset -> ALU write first, MEM next cycle, both busy bits cleared.
REQ-027 SHALL test: issue rd=5 while busy[5]=1 -> issue_ready=0; after write of r5 retires, issue_ready=1 and busy[5] set again.
REQ-028 SHALL test: mem beat rd=0 data=0xFFFF -> ready consumed, rf_write_en stays 0, busy unchanged.
REQ-029 SHALL test: 3 back-to-back alu beats with mem stream competing -> alu_ready=0 at count 2, no beat lost, order preserved per source.
REQ-030 SHALL test: rst asserted with both FIFOs full -> FIFOs empty, busy=0, rf_write_en=0 immediately; with WB_BYPASS_EN, byp_addr1=rf_write_addr=7 during write -> byp_hit1=1, byp_data1=rf_write_data.
